// File: rtl/cr_request_gen.sv
// Country-road request generator: synchronises and debounces the vehicle-loop sensor, queues waiting cars and drives x.
// Optional macro CR_EMERGENCY_EN adds a synchronised emerg input that forces and extends country-road requests.
module cr_request_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int DEPART_CYCLES   = 4,
    parameter int MIN_GREEN       = 8,
    parameter int MAX_GREEN       = 32,
    parameter int HOLDOFF         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_raw,
`ifdef CR_EMERGENCY_EN
    input  logic             emerg,
`endif
    input  logic [1:0]       cr,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             overflow
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GT_W   = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;
    localparam int DEP_W  = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [GT_W-1:0]   GT_MIN    = GT_W'(MIN_GREEN - 1);
    localparam logic [GT_W-1:0]   GT_LAST   = GT_W'(MAX_GREEN - 1);
    localparam logic [GT_W-1:0]   GT_ONE    = GT_W'(1);
    localparam logic [DEP_W-1:0]  DEP_LAST  = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [DEP_W-1:0]  DEP_ONE   = DEP_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SERVE   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic                   db_r;
    logic [DB_W-1:0]        db_cnt_r;
    logic                   arrival_s;
    logic                   departure_s;
    logic                   emerg_s;
    logic                   cr_green_s;
    logic                   cr_red_s;
    state_t                 state_r, state_s;
    logic [GT_W-1:0]        green_timer_r, green_timer_s;
    logic [DEP_W-1:0]       dep_timer_r, dep_timer_s;
    logic [HOLD_W-1:0]      hold_timer_r, hold_timer_s;

    assign s_s        = sync_r[SYNC_STAGES-1];
    assign cr_green_s = (cr == 2'd1);
    assign cr_red_s   = (cr == 2'd0) || (cr == 2'd3);
    // A car arrives on the edge where a rising sensor level finishes debouncing.
    assign arrival_s  = s_s && !db_r && (db_cnt_r == DB_LAST);

`ifdef CR_EMERGENCY_EN
    logic [SYNC_STAGES-1:0] emerg_sync_r;

    // Emergency request synchroniser (no debounce).
    always_ff @(posedge clk) begin
        if (rst) begin
            emerg_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            emerg_sync_r <= {emerg_sync_r[SYNC_STAGES-2:0], emerg};
        end
    end
    assign emerg_s = emerg_sync_r[SYNC_STAGES-1];
`else
    assign emerg_s = 1'b0;
`endif

    // Sensor synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sensor_raw};
        end
    end

    // Debouncer: the level changes only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_r     <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
        end else if (s_s == db_r) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            db_r     <= s_s;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            db_cnt_r <= db_cnt_r + DB_ONE;
        end
    end

    // Request FSM next-state and timer logic.
    always_comb begin
        state_s       = state_r;
        green_timer_s = green_timer_r;
        dep_timer_s   = dep_timer_r;
        hold_timer_s  = hold_timer_r;
        departure_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((car_count != {CNT_W{1'b0}}) || emerg_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cr_green_s) begin
                    state_s       = ST_SERVE;
                    green_timer_s = {GT_W{1'b0}};
                    dep_timer_s   = {DEP_W{1'b0}};
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_SERVE: begin
                if (!cr_green_s) begin
                    state_s = ST_RELEASE;
                end else begin
                    if (green_timer_r != GT_LAST) begin
                        green_timer_s = green_timer_r + GT_ONE;
                    end else begin
                        green_timer_s = green_timer_r;
                    end
                    if (dep_timer_r == DEP_LAST) begin
                        dep_timer_s = {DEP_W{1'b0}};
                        departure_s = (car_count != {CNT_W{1'b0}});
                    end else begin
                        dep_timer_s = dep_timer_r + DEP_ONE;
                    end
                    // The max-green exit is held off while an emergency is active.
                    if (((green_timer_r >= GT_MIN) && (car_count == {CNT_W{1'b0}}) && !arrival_s) ||
                        ((green_timer_r == GT_LAST) && !emerg_s)) begin
                        state_s = ST_RELEASE;
                    end else begin
                        state_s = ST_SERVE;
                    end
                end
            end
            ST_RELEASE: begin
                if (emerg_s) begin
                    state_s = ST_REQ;
                end else if (cr_red_s) begin
                    state_s      = ST_HOLDOFF;
                    hold_timer_s = HOLD_LAST;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            ST_HOLDOFF: begin
                if (emerg_s) begin
                    state_s = ST_REQ;
                end else if (hold_timer_r == {HOLD_W{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    hold_timer_s = hold_timer_r - HOLD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, timers and registered request output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            green_timer_r <= {GT_W{1'b0}};
            dep_timer_r   <= {DEP_W{1'b0}};
            hold_timer_r  <= {HOLD_W{1'b0}};
            x             <= 1'b0;
        end else begin
            state_r       <= state_s;
            green_timer_r <= green_timer_s;
            dep_timer_r   <= dep_timer_s;
            hold_timer_r  <= hold_timer_s;
            x             <= (state_s == ST_REQ) || (state_s == ST_SERVE);
        end
    end

    // Vehicle queue: a coincident arrival and departure cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            car_count <= {CNT_W{1'b0}};
            overflow  <= 1'b0;
        end else if (arrival_s && !departure_s) begin
            if (car_count == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                car_count <= car_count + CNT_ONE;
            end
        end else if (departure_s && !arrival_s) begin
            car_count <= car_count - CNT_ONE;
        end else begin
            car_count <= car_count;
        end
    end

endmodule

// File: tb/tb_cr_request_gen.sv
// Self-checking bench for cr_request_gen: directed scenarios plus randomized sensor/controller traffic
// compared cycle by cycle with a behavioural model of the request rules.
module tb_cr_request_gen;

    localparam int SS      = 2;
    localparam int DB      = 4;
    localparam int CNT_MAX = 15;
    localparam int DEP     = 4;
    localparam int MIN_G   = 8;
    localparam int MAX_G   = 32;
    localparam int HOLD    = 16;

    localparam int PH_IDLE    = 0;
    localparam int PH_REQ     = 1;
    localparam int PH_SERVE   = 2;
    localparam int PH_RELEASE = 3;
    localparam int PH_HOLD    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_raw = 1'b0;
    logic [1:0] cr = 2'd0;
    logic       x;
    logic [3:0] car_count;
    logic       overflow;
`ifdef CR_EMERGENCY_EN
    logic       emerg = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pipe[$];
    int m_db, m_run, m_phase, m_serve_n, m_hold_left, m_count, m_ovf, m_x;

    cr_request_gen dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
`ifdef CR_EMERGENCY_EN
        .emerg      (emerg),
`endif
        .cr         (cr),
        .x          (x),
        .car_count  (car_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SS; i++) m_pipe.push_back(0);
        m_db = 0; m_run = 0; m_phase = PH_IDLE; m_serve_n = 0;
        m_hold_left = 0; m_count = 0; m_ovf = 0; m_x = 0;
    endtask

    task automatic model_step(input int raw, input int crv, input int r);
        int s, arr, dep, nxt, green, red;
        if (r != 0) begin
            model_reset();
            return;
        end
        s = m_pipe.pop_front();
        m_pipe.push_back(raw);
        arr = 0;
        if (s != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db  = s;
                m_run = 0;
                arr   = s;
            end
        end else begin
            m_run = 0;
        end
        green = (crv == 1);
        red   = (crv == 0 || crv == 3);
        dep   = 0;
        nxt   = m_phase;
        case (m_phase)
            PH_IDLE:    if (m_count > 0) nxt = PH_REQ;
            PH_REQ:     if (green != 0) begin nxt = PH_SERVE; m_serve_n = 0; end
            PH_SERVE: begin
                if (green == 0) nxt = PH_RELEASE;
                else begin
                    m_serve_n++;
                    dep = ((m_serve_n % DEP) == 0 && m_count > 0) ? 1 : 0;
                    if ((m_serve_n >= MIN_G && m_count == 0 && arr == 0) || m_serve_n >= MAX_G)
                        nxt = PH_RELEASE;
                end
            end
            PH_RELEASE: if (red != 0) begin nxt = PH_HOLD; m_hold_left = HOLD; end
            PH_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) nxt = PH_IDLE;
            end
            default: nxt = PH_IDLE;
        endcase
        if (arr != 0 && dep == 0) begin
            if (m_count == CNT_MAX) m_ovf = 1;
            else m_count++;
        end else if (dep != 0 && arr == 0) begin
            m_count--;
        end
        m_phase = nxt;
        m_x = (nxt == PH_REQ || nxt == PH_SERVE) ? 1 : 0;
    endtask

    task automatic step(input int raw, input int crv, input int r);
        sensor_raw = raw[0];
        cr         = crv[1:0];
        rst        = r[0];
        @(posedge clk);
        model_step(raw, crv, r);
        @(negedge clk);
        check_eq("x", int'(x), m_x);
        check_eq("car_count", int'(car_count), m_count);
        check_eq("overflow", int'(overflow), m_ovf);
    endtask

    initial begin
        int ctl_ph, ctl_t, lvl, lvl_t, crv, r;
        model_reset();

        // Reset state
        step(0, 0, 1);
        step(0, 0, 1);
        check_eq("rst_x", int'(x), 0);
        check_eq("rst_cnt", int'(car_count), 0);
        check_eq("rst_ovf", int'(overflow), 0);

        // Short pulses are filtered
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 3; i++) step(1, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0);
        end
        check_eq("glitch_cnt", int'(car_count), 0);
        check_eq("glitch_x", int'(x), 0);

        // Arrival latency
        step(0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            if (i == 5) check_eq("lat_cnt5", int'(car_count), 0);
            if (i == 6) check_eq("lat_cnt6", int'(car_count), 1);
            if (i == 6) check_eq("lat_x6", int'(x), 0);
            if (i == 7) check_eq("lat_x7", int'(x), 1);
        end
        check_eq("lat_ovf", int'(overflow), 0);

        // Request held through yellow/all-red, then minimum green
        step(0, 0, 0);
        step(0, 2, 0);
        step(0, 2, 0);
        check_eq("hold_x", int'(x), 1);
        for (int i = 0; i <= 8; i++) begin
            step(0, 1, 0);
            if (i == 3) check_eq("min_cnt3", int'(car_count), 1);
            if (i == 4) check_eq("min_cnt4", int'(car_count), 0);
            if (i == 7) check_eq("min_x7", int'(x), 1);
            if (i == 8) check_eq("min_x8", int'(x), 0);
        end
        step(0, 2, 0);
        for (int i = 1; i <= 17; i++) step(0, 0, 0);

        // Saturation and maximum green
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 0);
            for (int i = 0; i < 5; i++) step(0, 0, 0);
        end
        check_eq("sat_cnt", int'(car_count), 15);
        check_eq("sat_ovf", int'(overflow), 1);
        for (int i = 0; i <= 32; i++) begin
            step(0, 1, 0);
            if (i == 31) check_eq("max_x31", int'(x), 1);
            if (i == 32) check_eq("max_x32", int'(x), 0);
            if (i == 32) check_eq("max_cnt", int'(car_count), 7);
        end
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, 0);
            if (i == 17) check_eq("holdoff_x17", int'(x), 0);
            if (i == 18) check_eq("holdoff_x18", int'(x), 1);
        end

        // Arrival coinciding with a departure wrap
        step(1, 0, 0);
        for (int i = 0; i <= 12; i++) begin
            step(1, 1, 0);
            if (i == 4) check_eq("simul_cnt", int'(car_count), 7);
            if (i == 12) check_eq("pre_rst_cnt", int'(car_count), 5);
        end

        // Reset during SERVE
        step(0, 1, 1);
        check_eq("mid_rst_x", int'(x), 0);
        check_eq("mid_rst_cnt", int'(car_count), 0);
        check_eq("mid_rst_ovf", int'(overflow), 0);
        step(0, 0, 0);
        check_eq("mid_rst_idle", int'(x), 0);

        // Randomized traffic with a simple controller emulation
        ctl_ph = 0; ctl_t = 0; lvl = 0; lvl_t = 0;
        for (int n = 0; n < 4000; n++) begin
            crv = 0;
            if (lvl_t == 0) begin
                lvl   = int'($urandom_range(0, 1));
                lvl_t = int'($urandom_range(1, 10));
            end
            lvl_t--;
            case (ctl_ph)
                0: begin
                    crv = ($urandom_range(0, 3) == 0) ? 3 : 0;
                    if (m_x == 1 && $urandom_range(0, 3) == 0) ctl_ph = 1;
                end
                1: begin
                    crv = 1;
                    if (m_x == 0 || $urandom_range(0, 199) == 0) begin
                        ctl_ph = 2;
                        ctl_t  = 2;
                    end
                end
                2: begin
                    crv = 2;
                    ctl_t--;
                    if (ctl_t == 0) ctl_ph = 0;
                end
                default: ctl_ph = 0;
            endcase
            r = ($urandom_range(0, 699) == 0) ? 1 : 0;
            step(lvl, crv, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
